int_req_arbiter: RTL and testbench
==================================

# int_req_arbiter

Interrupt request front end for the multi-interrupt pipelined CPU. It turns four raw request lines into latched pending requests, tracks which sources are in service so that interrupts can nest, and picks the highest-priority eligible source. For each accepted interrupt it issues a one-cycle break pulse and a 2-bit source code to the interrupt controller stage directly downstream. That controller redirects the PC, and on `eret` returns a one-hot in-service-clear vector that this block consumes.

## Interface
Parameters: none (source count fixed at 4).

- `in_CLK`  input  1  system clock; all state changes on its rising edge
- `in_RST`  input  1  reset; synchronous, active-low
- `in_IR`  input  4  raw interrupt request lines; bit 3 = highest priority
- `in_IE`  input  1  global interrupt enable (EI/DI state)
- `in_NIE`  input  1  nesting-enable from the interrupt controller; 0 = no new break may issue
- `in_IG`  input  4  one-hot in-service clear from the interrupt controller (eret); 1-cycle pulse
- `in_stall`  input  1  pipeline stall; no break issues while high
- `out_BK`  output  1  break request pulse, exactly 1 cycle per accepted interrupt
- `out_code`  output  2  index of the accepted source; valid in the `out_BK` cycle and held until the next issue
- `out_pending`  output  4  pending request register (for display LEDs)
- `out_ISR`  output  4  in-service register

## Operation
- Edge detect: `prev` register holds last sampled `in_IR`. `rise = in_IR & ~prev` sets `pending[i]`. Levels held high do not re-trigger.
- Eligibility: a pending source is eligible only if it is not in service and its index is greater than the highest index in `out_ISR`. If `out_ISR` = 0, all pending sources are eligible. Among eligible sources, the highest index wins.
- Issue conditions: eligible ≠ 0, `in_IE`=1, `in_NIE`=1, `in_stall`=0, state = IDLE.
- On issue:
  - `out_BK`←1 and `out_code`←winner.
  - `pending[winner]`←0 and `out_ISR[winner]`←1.
- `in_IG[i]`=1 clears `out_ISR[i]`. The pending bit is unaffected.
- Nesting depth is at most 4 (one level per source).
- FSM (2-bit state plus 2-bit hold counter):
  - IDLE → ISSUE when the issue conditions hold.
  - ISSUE (`out_BK`=1) → HOLD, counter loaded with 2.
  - HOLD decrements the counter each cycle and returns to IDLE at 0.
  - HOLD covers the controller's 1-cycle `in_NIE` response latency plus pipeline flush.
- Simultaneous events:
  - A rising edge on the source being issued in the same cycle: set wins, and `pending` stays 1.
  - `in_IG[i]` in the same cycle as the issue of a different source: both take effect.
  - `in_IG` with more than one bit set: all indicated bits clear.
  - `in_IG` during HOLD is honoured.
- Reset (`in_RST`=0 at a clock edge), including mid-FSM:
  - state←IDLE, counter←0.
  - `prev`, `pending`, `out_ISR`←0.
  - `out_BK`←0, `out_code`←2'b00, `out_pending`←0.
  - Sync flops (if built)←0.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- `in_IR[i]` rises and is sampled at edge N: `pending[i]`=1 after edge N. With the pipeline idle and eligible, `out_BK`=1 after edge N+1, for one cycle.
- Minimum spacing between two `out_BK` pulses: 4 cycles (ISSUE + 2 HOLD + IDLE evaluation).
- `in_IG[i]` at edge M: `out_ISR[i]`=0 after edge M. A lower-priority pending source may issue at edge M+1 at the earliest.
- `in_stall` or `in_NIE`=0 only delays issue. `pending` is retained indefinitely.

## Configuration
- `INT_SYNC_EN` defined: `in_IR` passes through a 2-flop synchronizer before edge detection. Input-to-`pending` latency grows by 2 cycles, so `out_BK` follows at edge N+3.
- `INT_SYNC_EN` undefined: `in_IR` is treated as synchronous to `in_CLK` and sampled directly, with the latencies given above.

## Test plan
- Reset, then `in_IR`=4'b0100 pulse with `in_IE`=`in_NIE`=1: `out_BK` 1-cycle pulse 2 cycles after the edge, `out_code`=2, `out_ISR`=4'b0100, `out_pending`=0.
- Simultaneous rises on 4'b0011: source 1 issues first. Source 0 stays pending and is not eligible until `in_IG`=4'b0010; it then issues with `out_code`=0.
- Nesting: source 1 in service, then `in_IR[3]` rises: second `out_BK` with `out_code`=3 and `out_ISR`=4'b1010. `in_IR[0]` rising meanwhile stays pending.
- Hold `in_stall`=1 (or `in_IE`=0) for 10 cycles with source 2 pending: no `out_BK`. Release: `out_BK` on the next cycle, `out_code`=2.
- Rise on the issuing source in its ISSUE cycle: `pending` bit remains 1 after the issue.
- Assert `in_RST`=0 during HOLD with `pending`=4'b1000: all outputs 0 after the edge. No `out_BK` after release until a new rising edge.

Source files
------------

// File: rtl/int_req_arbiter.sv
// Interrupt request front end: edge-detects 4 request lines, tracks in-service
// sources for nesting and issues one break pulse per accepted interrupt.
// Optional INT_SYNC_EN adds a 2-flop synchronizer on in_IR.
module int_req_arbiter (
  input  logic       in_CLK,
  input  logic       in_RST,
  input  logic [3:0] in_IR,
  input  logic       in_IE,
  input  logic       in_NIE,
  input  logic [3:0] in_IG,
  input  logic       in_stall,
  output logic       out_BK,
  output logic [1:0] out_code,
  output logic [3:0] out_pending,
  output logic [3:0] out_ISR
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_HOLD = 2'd2} state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_prev;
  logic [3:0] w_ir, w_rise, w_above, w_elig, w_set;
  logic [1:0] w_win;
  logic       w_issue;

`ifdef INT_SYNC_EN
  logic [3:0] r_sync1, r_sync2;
  always_ff @(posedge in_CLK) begin
    if (!in_RST) begin
      r_sync1 <= 4'b0;
      r_sync2 <= 4'b0;
    end else begin
      r_sync1 <= in_IR;
      r_sync2 <= r_sync1;
    end
  end
  assign w_ir = r_sync2;
`else
  assign w_ir = in_IR;
`endif

  assign w_rise = w_ir & ~r_prev;

  // Only sources strictly above the highest in-service index may nest.
  always_comb begin
    w_above = 4'b1111;
    if      (out_ISR[3]) w_above = 4'b0000;
    else if (out_ISR[2]) w_above = 4'b1000;
    else if (out_ISR[1]) w_above = 4'b1100;
    else if (out_ISR[0]) w_above = 4'b1110;
  end

  assign w_elig = out_pending & ~out_ISR & w_above;

  always_comb begin
    w_win = 2'd0;
    if      (w_elig[3]) w_win = 2'd3;
    else if (w_elig[2]) w_win = 2'd2;
    else if (w_elig[1]) w_win = 2'd1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((|w_elig) && in_IE && in_NIE && !in_stall) begin
          w_issue     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_HOLD;
        w_cnt_nxt   = 2'd2;
      end
      S_HOLD: begin
        if (r_cnt <= 2'd1) begin
          w_cnt_nxt   = 2'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  assign w_set = w_issue ? (4'b0001 << w_win) : 4'b0000;

  // A rise on the source being issued re-arms it (set beats clear).
  always_ff @(posedge in_CLK) begin
    if (!in_RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_prev      <= 4'b0;
      out_pending <= 4'b0;
      out_ISR     <= 4'b0;
      out_BK      <= 1'b0;
      out_code    <= 2'b00;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_prev      <= w_ir;
      out_pending <= (out_pending & ~w_set) | w_rise;
      out_ISR     <= (out_ISR & ~in_IG) | w_set;
      out_BK      <= w_issue;
      if (w_issue) out_code <= w_win;
    end
  end

endmodule

// File: tb/tb_int_req_arbiter.sv
// Scoreboard bench for int_req_arbiter: directed stimulus pushes expected
// break events; a forked monitor pops and compares on every out_BK pulse.
module tb_int_req_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ir, ig;
  logic       ie, nie, stall;
  logic       bk;
  logic [1:0] code;
  logic [3:0] pend, isr;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cyc;
    logic [1:0] code;
    logic [3:0] isr;
    logic [3:0] pend;
  } exp_t;
  exp_t q[$];

  int_req_arbiter dut (
    .in_CLK(clk), .in_RST(rst_n), .in_IR(ir), .in_IE(ie), .in_NIE(nie),
    .in_IG(ig), .in_stall(stall), .out_BK(bk), .out_code(code),
    .out_pending(pend), .out_ISR(isr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_bk(input int dly, input logic [1:0] c, input logic [3:0] i, input logic [3:0] p);
    exp_t e;
    e.cyc = cyc + dly; e.code = c; e.isr = i; e.pend = p;
    q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; ir = 4'b0; ig = 4'b0; ie = 1'b0; nie = 1'b0; stall = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (bk === 1'b1) begin
          if (q.size() == 0) chk("unexpected_bk", 1, 0);
          else begin
            exp_t e;
            e = q.pop_front();
            chk("bk_cycle", cyc, e.cyc);
            chk("bk_code", code, e.code);
            chk("bk_isr", isr, e.isr);
            chk("bk_pending", pend, e.pend);
          end
        end
      end
    join_none

    tick(3);
    chk("rst_bk", bk, 0);
    chk("rst_code", code, 0);
    chk("rst_pending", pend, 0);
    chk("rst_isr", isr, 0);
    rst_n = 1'b1; ie = 1'b1; nie = 1'b1;
    tick(1);

    // single pulse on source 2
    ir = 4'b0100; expect_bk(2, 2'd2, 4'b0100, 4'b0000);
    tick(1); ir = 4'b0000;
    chk("t1_pending", pend, 4'b0100);
    tick(6);
    chk("t1_isr", isr, 4'b0100);
    ig = 4'b0100; tick(1); ig = 4'b0000;
    chk("t1_isr_clr", isr, 4'b0000);
    tick(2);

    // simultaneous rises on 0 and 1, levels held
    ir = 4'b0011; expect_bk(2, 2'd1, 4'b0010, 4'b0001);
    tick(10);
    chk("t2_pending", pend, 4'b0001);
    ig = 4'b0010; expect_bk(2, 2'd0, 4'b0001, 4'b0000);
    tick(1); ig = 4'b0000;
    tick(6);
    ir = 4'b0000; ig = 4'b0001; tick(1); ig = 4'b0000; tick(2);
    chk("t2_isr_clr", isr, 4'b0000);

    // nesting: 3 preempts 1, 0 stays pending
    ir = 4'b0010; expect_bk(2, 2'd1, 4'b0010, 4'b0000);
    tick(2);
    ir = 4'b1001; expect_bk(4, 2'd3, 4'b1010, 4'b0001);
    tick(8);
    chk("t3_pending", pend, 4'b0001);
    chk("t3_isr", isr, 4'b1010);
    ig = 4'b1010; expect_bk(2, 2'd0, 4'b0001, 4'b0000);
    tick(1); ig = 4'b0000; ir = 4'b0000;
    tick(6);
    ig = 4'b0001; tick(1); ig = 4'b0000; tick(1);

    // stall / IE / NIE gating only delays issue
    for (int j = 0; j < 3; j++) begin
      stall = (j == 0); ie = (j != 1); nie = (j != 2);
      ir = 4'b0100; tick(1); ir = 4'b0000;
      tick(10);
      chk("t4_pending_held", pend, 4'b0100);
      stall = 1'b0; ie = 1'b1; nie = 1'b1;
      expect_bk(1, 2'd2, 4'b0100, 4'b0000);
      tick(6);
      ig = 4'b0100; tick(1); ig = 4'b0000; tick(1);
    end

    // rise on the issuing source in its issue cycle
    stall = 1'b1;
    ir = 4'b1000; tick(1); ir = 4'b0000; tick(2);
    stall = 1'b0; ir = 4'b1000; expect_bk(1, 2'd3, 4'b1000, 4'b1000);
    tick(7);
    chk("t5_pending", pend, 4'b1000);
    chk("t5_code_held", code, 2'd3);
    ir = 4'b0000;

    // reset during HOLD with source 3 pending
    ig = 4'b1000; expect_bk(2, 2'd3, 4'b1000, 4'b0000);
    tick(1); ig = 4'b0000;
    tick(1);
    ir = 4'b1000; tick(1);
    chk("t6_pending_pre", pend, 4'b1000);
    rst_n = 1'b0; ir = 4'b0000; tick(1);
    chk("t6_bk", bk, 0);
    chk("t6_code", code, 0);
    chk("t6_pending", pend, 0);
    chk("t6_isr", isr, 0);
    rst_n = 1'b1; tick(10);
    chk("t6_pending_post", pend, 0);
    ir = 4'b0001; expect_bk(2, 2'd0, 4'b0001, 4'b0000);
    tick(1); ir = 4'b0000;
    tick(6);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("missing_bk", 0, e.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
